// File: rtl/neo_strand_ctrl.sv
// NeoPixel-style single-wire strand controller: per-pixel colour storage plus serial frame transmitter.
// Define NEO_RGBW_EN to add a W channel per pixel (32 bits per pixel instead of 24).
module neo_strand_ctrl #(
    parameter int NUM_PIXELS = 5,
    parameter int PIX_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1,
    parameter int T0H        = 18,
    parameter int T1H        = 35,
    parameter int TBIT       = 63,
    parameter int TLATCH     = 2500
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       color_level,
    input  logic [1:0]       color_index,
    input  logic [PIX_W-1:0] pixel_index,
    input  logic             load_color,
    input  logic             send_it,
    output logic             neo_data,
    output logic             ready_to_load,
    output logic             ready_to_send
);

`ifdef NEO_RGBW_EN
    localparam int CHANNELS = 4;
`else
    localparam int CHANNELS = 3;
`endif
    localparam int CW = (TBIT > 1) ? $clog2(TBIT) : 1;
    localparam int LW = (TLATCH > 1) ? $clog2(TLATCH) : 1;

    localparam logic [CW-1:0]    CYC_LAST   = CW'(TBIT - 1);
    localparam logic [CW-1:0]    HIGH_ONE   = CW'(T1H);
    localparam logic [CW-1:0]    HIGH_ZERO  = CW'(T0H);
    localparam logic [LW-1:0]    LATCH_LAST = LW'(TLATCH - 1);
    localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(NUM_PIXELS - 1);
    localparam logic [PIX_W:0]   PIX_COUNT  = (PIX_W + 1)'(NUM_PIXELS);
    localparam logic [1:0]       CHAN_LAST  = 2'(CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        LATCH
    } state_t;

    state_t           stateQ, stateD;
    logic [CW-1:0]    cycleQ, cycleD;
    logic [2:0]       bitQ, bitD;
    logic [1:0]       chanQ, chanD;
    logic [PIX_W-1:0] pixQ, pixD;
    logic [LW-1:0]    latchQ, latchD;
    logic             neoQ, neoD;

    logic [7:0] gQ [NUM_PIXELS];
    logic [7:0] rQ [NUM_PIXELS];
    logic [7:0] bQ [NUM_PIXELS];
`ifdef NEO_RGBW_EN
    logic [7:0] wQ [NUM_PIXELS];
`endif

    logic       loadOk;
    logic [7:0] curByte;
    logic       curBit;
    logic [CW-1:0] highLen;

    assign loadOk = (stateQ == IDLE) && load_color && ({1'b0, pixel_index} < PIX_COUNT);

    // Colour registers only change in IDLE, so a frame in flight sees a frozen snapshot.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                gQ[i] <= 8'h00;
                rQ[i] <= 8'h00;
                bQ[i] <= 8'h00;
`ifdef NEO_RGBW_EN
                wQ[i] <= 8'h00;
`endif
            end
        end else if (loadOk) begin
            case (color_index)
                2'd0: rQ[pixel_index] <= color_level;
                2'd1: bQ[pixel_index] <= color_level;
                2'd2: gQ[pixel_index] <= color_level;
`ifdef NEO_RGBW_EN
                2'd3: wQ[pixel_index] <= color_level;
`endif
                default: ;
            endcase
        end
    end

    // Wire order per pixel is G, R, B (, W), independent of the load-side channel numbering.
    always_comb begin
        curByte = 8'h00;
        case (chanQ)
            2'd0: curByte = gQ[pixQ];
            2'd1: curByte = rQ[pixQ];
            2'd2: curByte = bQ[pixQ];
`ifdef NEO_RGBW_EN
            2'd3: curByte = wQ[pixQ];
`endif
            default: curByte = 8'h00;
        endcase
    end

    assign curBit  = curByte[bitQ];
    assign highLen = curBit ? HIGH_ONE : HIGH_ZERO;

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ <= IDLE;
            cycleQ <= '0;
            bitQ   <= '0;
            chanQ  <= '0;
            pixQ   <= '0;
            latchQ <= '0;
            neoQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            cycleQ <= cycleD;
            bitQ   <= bitD;
            chanQ  <= chanD;
            pixQ   <= pixD;
            latchQ <= latchD;
            neoQ   <= neoD;
        end
    end

    always_comb begin
        stateD = stateQ;
        cycleD = cycleQ;
        bitD   = bitQ;
        chanD  = chanQ;
        pixD   = pixQ;
        latchD = latchQ;
        neoD   = 1'b0;
        case (stateQ)
            IDLE: begin
                if (send_it) begin
                    stateD = SEND;
                    cycleD = '0;
                    bitD   = 3'd7;
                    chanD  = '0;
                    pixD   = '0;
                end
            end
            SEND: begin
                neoD = (cycleQ < highLen);
                if (cycleQ == CYC_LAST) begin
                    cycleD = '0;
                    if (bitQ == 3'd0) begin
                        bitD = 3'd7;
                        if (chanQ == CHAN_LAST) begin
                            chanD = '0;
                            if (pixQ == PIX_LAST) begin
                                pixD   = '0;
                                latchD = '0;
                                stateD = LATCH;
                            end else begin
                                pixD = pixQ + 1'b1;
                            end
                        end else begin
                            chanD = chanQ + 1'b1;
                        end
                    end else begin
                        bitD = bitQ - 1'b1;
                    end
                end else begin
                    cycleD = cycleQ + 1'b1;
                end
            end
            LATCH: begin
                if (latchQ == LATCH_LAST) begin
                    latchD = '0;
                    stateD = IDLE;
                end else begin
                    latchD = latchQ + 1'b1;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    assign neo_data      = neoQ;
    assign ready_to_load = (stateQ == IDLE);
    assign ready_to_send = (stateQ == IDLE);

endmodule

// File: tb/tb_neo_strand_ctrl.sv
// Randomized bench for neo_strand_ctrl against a pixel-array model; honours NEO_RGBW_EN like the design.
module tb_neo_strand_ctrl;

    localparam int NUM_PIXELS = 5;
    localparam int PIX_W      = 3;
    localparam int T0H        = 18;
    localparam int T1H        = 35;
    localparam int TBIT       = 63;
    localparam int TLATCH     = 2500;
`ifdef NEO_RGBW_EN
    localparam int CH = 4;
`else
    localparam int CH = 3;
`endif
    localparam int NBITS = NUM_PIXELS * CH * 8;

    logic             clock = 1'b0;
    logic             reset;
    logic [7:0]       color_level;
    logic [1:0]       color_index;
    logic [PIX_W-1:0] pixel_index;
    logic             load_color;
    logic             send_it;
    logic             neo_data;
    logic             ready_to_load;
    logic             ready_to_send;

    int checks = 0;
    int errors = 0;

    logic [7:0] mG [NUM_PIXELS];
    logic [7:0] mR [NUM_PIXELS];
    logic [7:0] mB [NUM_PIXELS];
    logic [7:0] mW [NUM_PIXELS];

    neo_strand_ctrl #(
        .NUM_PIXELS(NUM_PIXELS),
        .T0H(T0H),
        .T1H(T1H),
        .TBIT(TBIT),
        .TLATCH(TLATCH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .color_level(color_level),
        .color_index(color_index),
        .pixel_index(pixel_index),
        .load_color(load_color),
        .send_it(send_it),
        .neo_data(neo_data),
        .ready_to_load(ready_to_load),
        .ready_to_send(ready_to_send)
    );

    always #10 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic void modelClear();
        for (int p = 0; p < NUM_PIXELS; p++) begin
            mG[p] = 8'h00;
            mR[p] = 8'h00;
            mB[p] = 8'h00;
            mW[p] = 8'h00;
        end
    endfunction

    // Model of a load accepted in IDLE; out-of-range pixels and absent channels are dropped.
    function automatic void modelLoad(input int pix, input int ci, input int lvl);
        if (pix < NUM_PIXELS) begin
            case (ci)
                0: mR[pix] = lvl[7:0];
                1: mB[pix] = lvl[7:0];
                2: mG[pix] = lvl[7:0];
`ifdef NEO_RGBW_EN
                3: mW[pix] = lvl[7:0];
`endif
                default: ;
            endcase
        end
    endfunction

    task automatic applyStimulus(input int pix, input int ci, input int lvl);
        @(negedge clock);
        pixel_index = pix[PIX_W-1:0];
        color_index = ci[1:0];
        color_level = lvl[7:0];
        load_color  = 1'b1;
        modelLoad(pix, ci, lvl);
        @(negedge clock);
        load_color = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge clock);
        send_it    = 1'b0;
        load_color = 1'b0;
        reset      = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        modelClear();
    endtask

    task automatic runFrame(input string name, input bit loadWithSend, input int pix, input int ci,
                            input int lvl, input bit midLoad, input bit holdSend, input int abortBit);
        bit   expBits[$];
        logic [7:0] byteVal;
        int   readyLow, highs, tailHigh;
        bit   shapeBad, done;

        @(negedge clock);
        checkOutput({name, "_ready_before"}, int'(ready_to_send), 1);
        send_it = 1'b1;
        if (loadWithSend) begin
            pixel_index = pix[PIX_W-1:0];
            color_index = ci[1:0];
            color_level = lvl[7:0];
            load_color  = 1'b1;
            modelLoad(pix, ci, lvl);
        end

        for (int p = 0; p < NUM_PIXELS; p++) begin
            for (int c = 0; c < CH; c++) begin
                byteVal = (c == 0) ? mG[p] : (c == 1) ? mR[p] : (c == 2) ? mB[p] : mW[p];
                for (int i = 7; i >= 0; i--) expBits.push_back(byteVal[i]);
            end
        end

        @(negedge clock);
        if (!holdSend) send_it = 1'b0;
        load_color = 1'b0;
        checkOutput({name, "_start_neo"}, int'(neo_data), 0);
        checkOutput({name, "_start_busy"}, int'(ready_to_send), 0);
        readyLow = (ready_to_send == 1'b0) ? 1 : 0;

        for (int b = 0; b < NBITS; b++) begin
            highs    = 0;
            shapeBad = 1'b0;
            for (int c = 0; c < TBIT; c++) begin
                @(negedge clock);
                if (b == abortBit && c == 0) begin
                    send_it    = 1'b0;
                    reset      = 1'b1;
                    @(negedge clock);
                    checkOutput({name, "_abort_neo"}, int'(neo_data), 0);
                    checkOutput({name, "_abort_rdy_load"}, int'(ready_to_load), 1);
                    checkOutput({name, "_abort_rdy_send"}, int'(ready_to_send), 1);
                    reset = 1'b0;
                    modelClear();
                    return;
                end
                if (midLoad && b == 10) begin
                    if (c == 0) begin
                        pixel_index = 3'd1;
                        color_index = 2'd1;
                        color_level = 8'hFF;
                        load_color  = 1'b1;
                        checkOutput({name, "_midload_rdy"}, int'(ready_to_load), 0);
                    end else if (c == 1) begin
                        load_color = 1'b0;
                    end
                end
                if (ready_to_send == 1'b0) readyLow++;
                if (neo_data == 1'b1) begin
                    if (c != highs) shapeBad = 1'b1;
                    highs++;
                end
            end
            checkOutput($sformatf("%s_bit%0d_high", name, b), shapeBad ? -1 : highs,
                        expBits[b] ? T1H : T0H);
        end

        tailHigh = 0;
        done     = 1'b0;
        for (int i = 0; i < TLATCH + 100 && !done; i++) begin
            @(negedge clock);
            if (ready_to_send == 1'b1) done = 1'b1;
            else begin
                readyLow++;
                if (neo_data == 1'b1) tailHigh++;
            end
        end
        checkOutput({name, "_back_idle"}, int'(done), 1);
        checkOutput({name, "_busy_cycles"}, readyLow, NBITS * TBIT + TLATCH);
        checkOutput({name, "_latch_high"}, tailHigh, 0);
        checkOutput({name, "_idle_neo"}, int'(neo_data), 0);
        checkOutput({name, "_idle_rdy_load"}, int'(ready_to_load), 1);

        if (holdSend) begin
            @(negedge clock);
            checkOutput({name, "_hold_restart"}, int'(ready_to_send), 0);
            resetDut();
        end
    endtask

    initial begin
        reset       = 1'b1;
        send_it     = 1'b0;
        load_color  = 1'b0;
        color_level = 8'h00;
        color_index = 2'd0;
        pixel_index = '0;
        modelClear();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset_rdy_load", int'(ready_to_load), 1);
        checkOutput("reset_rdy_send", int'(ready_to_send), 1);
        checkOutput("reset_neo", int'(neo_data), 0);

        runFrame("dflt", 1'b0, 0, 0, 0, 1'b0, 1'b0, -1);

        applyStimulus(0, 2, 8'h80);
        runFrame("g80", 1'b0, 0, 0, 0, 1'b0, 1'b0, -1);

        resetDut();
        applyStimulus(5, 0, 8'hFF);
        applyStimulus(2, 3, 8'h5A);
        runFrame("oob", 1'b0, 0, 0, 0, 1'b1, 1'b0, -1);

        for (int i = 0; i < 10; i++)
            applyStimulus($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 255));
        runFrame("rand", 1'b1, $urandom_range(0, NUM_PIXELS - 1), $urandom_range(0, 2),
                 $urandom_range(1, 255), 1'b0, 1'b1, -1);

        for (int i = 0; i < 6; i++)
            applyStimulus($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 255));
        runFrame("abort", 1'b0, 0, 0, 0, 1'b0, 1'b0, 40);

        applyStimulus(4, 3, 8'h01);
        runFrame("post", 1'b0, 0, 0, 0, 1'b0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
